// File: rtl/zube_fifo_mailbox.sv
// -----------------------------------------------------------------------------
// zube_fifo_mailbox
//
// Z80 <-> Caravel mailbox built from two byte FIFOs:
//   H2Z : written by the Wishbone host (DATA), read by the Z80 (port base+0)
//   Z2H : written by the Z80 (port base+0), read by the Wishbone host (DATA)
// Sticky error flags, level status, a maskable level IRQ and a relocatable
// Z80 I/O port base. The block drives its own pad output-enables.
//
// Optional feature macro: ZUBE_FIFO_THRESH_EN
//   defined   : THRESH register (+12) and IRQ_EN[2] threshold source exist
//   undefined : +12 is acked, reads 0, ignores writes; IRQ_EN[2] reads 0
//
// Ports:
//   clk          sole clock (Wishbone clock)
//   reset_b      asynchronous active-low reset
//   io_in[27:0]  [7:0] Z80 addr, [15:8] Z80 data in, [16] wr_b, [17] rd_b
//   io_out[27:0] [15:8] Z80 data out, [18] bus_dir, other bits 0
//   io_oeb[27:0] [15:8] driven while bus_dir, [18] always driven, others input
//   wb_*         classic Wishbone slave; DATA +0, STATUS +4, IRQ_EN +8,
//                THRESH +12 relative to BASE_ADDRESS
//   irq_out      registered OR of enabled interrupt sources
// -----------------------------------------------------------------------------

// Byte FIFO with level counter. Overflow/underflow are single-cycle pulses
// reporting a rejected push (full) or a rejected pop (empty); both use the
// pre-cycle state, so a full FIFO rejects a push even while popping and an
// empty FIFO rejects a pop even while pushing.
module zube_fifo_mailbox_fifo #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign overflow  = push & full;
  assign underflow = pop & empty;
  assign head      = mem[rd_ptr];

  // NOTE: storage has no reset on purpose; emptiness is defined by the
  // pointers and level, so a reset discards contents without clearing RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module zube_fifo_mailbox #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h3000_0000,
  parameter logic [7:0]  Z80_PORT_BASE = 8'h80,
  parameter int          DEPTH         = 8
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [27:0] io_in,
  output logic [27:0] io_out,
  output logic [27:0] io_oeb,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  input  logic [31:0] wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        wb_ack_out,
  output logic [31:0] wb_data_out,
  output logic        irq_out
);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_IRQ_EN = 2'd2,
    REG_THRESH = 2'd3
  } reg_sel_e;

  // ---------------------------------------------------------------------------
  // Z80 bus synchronisation. Address and data travel through the same two-flop
  // pipeline as the strobes, so the copy seen at a synchronised edge is the
  // one that was on the bus when the strobe itself was sampled.
  // ---------------------------------------------------------------------------
  logic [1:0] rd_sync;
  logic [1:0] wr_sync;
  logic       rd_prev;
  logic       wr_prev;
  logic [7:0] addr_s1, addr_s2;
  logic [7:0] data_s1, data_s2;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      // Strobes idle high so leaving reset never fakes an edge.
      rd_sync <= 2'b11;
      wr_sync <= 2'b11;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
      addr_s1 <= '0;
      addr_s2 <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      rd_sync <= {rd_sync[0], io_in[17]};
      wr_sync <= {wr_sync[0], io_in[16]};
      rd_prev <= rd_sync[1];
      wr_prev <= wr_sync[1];
      addr_s1 <= io_in[7:0];
      addr_s2 <= addr_s1;
      data_s1 <= io_in[15:8];
      data_s2 <= data_s1;
    end
  end

  logic rd_fall, rd_rise, wr_rise;
  logic z_port_data, z_port_stat;

  assign rd_fall     = rd_prev & ~rd_sync[1];
  assign rd_rise     = ~rd_prev & rd_sync[1];
  assign wr_rise     = ~wr_prev & wr_sync[1];
  assign z_port_data = (addr_s2 == Z80_PORT_BASE);
  assign z_port_stat = (addr_s2 == Z80_PORT_BASE + 8'd1);

  // ---------------------------------------------------------------------------
  // Wishbone decode. One transfer per ack: a request is only taken while ack
  // is low, which also enforces the idle cycle between back-to-back acks.
  // ---------------------------------------------------------------------------
  logic [31:0] wb_offset;
  logic        wb_hit;
  logic        wb_xfer;
  reg_sel_e    reg_sel;

  assign wb_offset = wb_addr_in - BASE_ADDRESS;
  assign wb_hit    = (wb_offset[31:4] == '0) && (wb_offset[1:0] == 2'b00);
  assign wb_xfer   = wb_cyc_in & wb_stb_in & wb_hit & ~wb_ack_out;
  assign reg_sel   = reg_sel_e'(wb_offset[3:2]);

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  logic          h2z_push, h2z_pop, z2h_push, z2h_pop;
  logic [7:0]    h2z_head, z2h_head;
  logic [LW-1:0] h2z_level, z2h_level;
  logic          h2z_empty, h2z_full, h2z_ovf, h2z_udf;
  logic          z2h_empty, z2h_full, z2h_ovf, z2h_udf;

  assign h2z_push = wb_xfer & wb_we_in & (reg_sel == REG_DATA);
  assign z2h_pop  = wb_xfer & ~wb_we_in & (reg_sel == REG_DATA);
  assign h2z_pop  = rd_fall & z_port_data;
  assign z2h_push = wr_rise & z_port_data;

  zube_fifo_mailbox_fifo #(.DEPTH(DEPTH), .LW(LW)) u_h2z (
    .clk       (clk),
    .reset_b   (reset_b),
    .push      (h2z_push),
    .push_data (wb_data_in[7:0]),
    .pop       (h2z_pop),
    .head      (h2z_head),
    .level     (h2z_level),
    .empty     (h2z_empty),
    .full      (h2z_full),
    .overflow  (h2z_ovf),
    .underflow (h2z_udf)
  );

  zube_fifo_mailbox_fifo #(.DEPTH(DEPTH), .LW(LW)) u_z2h (
    .clk       (clk),
    .reset_b   (reset_b),
    .push      (z2h_push),
    .push_data (data_s2),
    .pop       (z2h_pop),
    .head      (z2h_head),
    .level     (z2h_level),
    .empty     (z2h_empty),
    .full      (z2h_full),
    .overflow  (z2h_ovf),
    .underflow (z2h_udf)
  );

  // ---------------------------------------------------------------------------
  // Control/status registers
  // flags: [3] H2Z_OVERFLOW [2] Z2H_OVERFLOW [1] H2Z_UNDERFLOW [0] Z2H_UNDERFLOW
  // ---------------------------------------------------------------------------
  logic [3:0] flags;
  logic [3:0] flag_set;
  logic [3:0] flag_clr;
  logic [2:0] irq_en;
`ifdef ZUBE_FIFO_THRESH_EN
  logic [LW-1:0] thresh;
`endif

  assign flag_set = {h2z_ovf, z2h_ovf, h2z_udf, z2h_udf};
  assign flag_clr = (wb_xfer && wb_we_in && reg_sel == REG_STATUS) ?
                    wb_data_in[31:28] : 4'b0000;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      flags  <= '0;
      irq_en <= '0;
`ifdef ZUBE_FIFO_THRESH_EN
      thresh <= '0;
`endif
    end else begin
      // A new error in the clearing cycle survives the clear.
      flags <= flag_set | (flags & ~flag_clr);
      if (wb_xfer && wb_we_in && reg_sel == REG_IRQ_EN) begin
`ifdef ZUBE_FIFO_THRESH_EN
        irq_en <= wb_data_in[2:0];
`else
        irq_en <= {1'b0, wb_data_in[1:0]};
`endif
      end
`ifdef ZUBE_FIFO_THRESH_EN
      if (wb_xfer && wb_we_in && reg_sel == REG_THRESH) thresh <= wb_data_in[LW-1:0];
`endif
    end
  end

  logic [31:0] status_word;
  logic [31:0] rdata;

  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    status_word             = '0;
    status_word[LW-1:0]     = z2h_level;
    status_word[16 +: LW]   = h2z_level;
    status_word[31:28]      = flags;

    rdata = '0;
    case (reg_sel)
      REG_DATA:   rdata = z2h_empty ? 32'h0 : {24'h0, z2h_head};
      REG_STATUS: rdata = status_word;
      REG_IRQ_EN: rdata[2:0] = irq_en;
`ifdef ZUBE_FIFO_THRESH_EN
      REG_THRESH: rdata[LW-1:0] = thresh;
`else
      REG_THRESH: rdata = '0;
`endif
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wb_ack_out  <= 1'b0;
      wb_data_out <= '0;
    end else begin
      wb_ack_out  <= wb_xfer;
      wb_data_out <= (wb_xfer && !wb_we_in) ? rdata : 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------------
  logic thresh_src;
`ifdef ZUBE_FIFO_THRESH_EN
  assign thresh_src = irq_en[2] && (thresh != '0) && (z2h_level >= thresh);
`else
  assign thresh_src = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) irq_out <= 1'b0;
    else          irq_out <= (irq_en[0] & ~z2h_empty) | (irq_en[1] & h2z_empty) | thresh_src;
  end

  // ---------------------------------------------------------------------------
  // Z80 read data path and bus direction
  // ---------------------------------------------------------------------------
  logic       bus_dir;
  logic [7:0] z_dout;
  logic [7:0] z_status;

  assign z_status = {6'b0, z2h_full, ~h2z_empty};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bus_dir <= 1'b0;
      z_dout  <= '0;
    end else if (rd_fall && (z_port_data || z_port_stat)) begin
      bus_dir <= 1'b1;
      if (z_port_data) z_dout <= h2z_empty ? 8'h00 : h2z_head;
      else             z_dout <= z_status;
    end else if (rd_rise) begin
      bus_dir <= 1'b0;
      z_dout  <= '0;
    end
  end

  assign io_out = {9'b0, bus_dir, 2'b00, z_dout, 8'h00};
  assign io_oeb = {9'h1FF, 1'b0, 2'b11, {8{~bus_dir}}, 8'hFF};

  logic unused_bits;
  assign unused_bits = ^{io_in[27:18], wb_data_in[27:8]};
endmodule

// File: tb/tb_zube_fifo_mailbox.sv
`timescale 1ns/1ps
module tb_zube_fifo_mailbox;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] A_DATA   = BASE + 32'd0;
  localparam logic [31:0] A_STATUS = BASE + 32'd4;
  localparam logic [31:0] A_IRQEN  = BASE + 32'd8;
  localparam logic [31:0] A_THRESH = BASE + 32'd12;
  localparam logic [7:0]  PORT  = 8'h80;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [27:0] io_in, io_out, io_oeb;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdata;
  logic        wb_ack_out;
  logic [31:0] wb_data_out;
  logic        irq_out;

  logic [7:0]  z_addr, z_data;
  logic        z_rd_b, z_wr_b;

  assign io_in = {10'b0, z_rd_b, z_wr_b, z_data, z_addr};

  always #5 clk = ~clk;

  zube_fifo_mailbox #(.BASE_ADDRESS(BASE), .Z80_PORT_BASE(PORT), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .wb_cyc_in   (wb_cyc),
    .wb_stb_in   (wb_stb),
    .wb_we_in    (wb_we),
    .wb_addr_in  (wb_addr),
    .wb_data_in  (wb_wdata),
    .wb_ack_out  (wb_ack_out),
    .wb_data_out (wb_data_out),
    .irq_out     (irq_out)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: bytes expected out of each FIFO, plus expected sticky flags
  // {h2z_ovf, z2h_ovf, h2z_udf, z2h_udf}.
  logic [7:0] h2z_q[$];
  logic [7:0] z2h_q[$];
  logic [3:0] exp_flags = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {exp_flags, 12'(h2z_q.size()), 16'(z2h_q.size())};
  endfunction

  task automatic wb_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic acked);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wdata;
    acked = 1'b0; rdata = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (wb_ack_out) begin
        acked = 1'b1;
        rdata = wb_data_out;
        break;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_write(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        ack;
    wb_xact(1'b1, addr, wdata, rd, ack);
    check({tag, " ack"}, 32'(ack), 32'd1);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] addr, output logic [31:0] rd);
    logic ack;
    wb_xact(1'b0, addr, 32'h0, rd, ack);
    check({tag, " ack"}, 32'(ack), 32'd1);
  endtask

  task automatic host_push(input logic [7:0] b);
    wb_write("h2z push", A_DATA, {24'h0, b});
    if (h2z_q.size() < DEPTH) h2z_q.push_back(b);
    else exp_flags[3] = 1'b1;
  endtask

  task automatic host_pop(input string tag);
    logic [31:0] rd, exp;
    wb_read(tag, A_DATA, rd);
    if (z2h_q.size() > 0) exp = {24'h0, z2h_q.pop_front()};
    else begin exp = 32'h0; exp_flags[0] = 1'b1; end
    check(tag, rd, exp);
  endtask

  task automatic z80_read(input logic [7:0] port, output logic [7:0] data,
                          output logic [7:0] oeb_byte, output logic dir);
    @(negedge clk);
    z_addr = port; z_rd_b = 1'b0;
    repeat (6) @(negedge clk);
    data = io_out[15:8]; oeb_byte = io_oeb[15:8]; dir = io_out[18];
    z_rd_b = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic z80_pop(input string tag);
    logic [7:0] d, oeb;
    logic       dir;
    logic [7:0] exp;
    z80_read(PORT, d, oeb, dir);
    if (h2z_q.size() > 0) exp = h2z_q.pop_front();
    else begin exp = 8'h00; exp_flags[1] = 1'b1; end
    check(tag, 32'(d), 32'(exp));
    check({tag, " bus_dir"}, 32'(dir), 32'd1);
    check({tag, " oeb low"}, 32'(oeb), 32'h00);
  endtask

  task automatic z80_write(input logic [7:0] port, input logic [7:0] b);
    @(negedge clk);
    z_addr = port; z_data = b; z_wr_b = 1'b0;
    repeat (4) @(negedge clk);
    z_wr_b = 1'b1;
    repeat (6) @(negedge clk);
    if (port == PORT) begin
      if (z2h_q.size() < DEPTH) z2h_q.push_back(b);
      else exp_flags[2] = 1'b1;
    end
  endtask

  // Z80 push into Z2H lands on the same clock edge as a Wishbone DATA read:
  // the synced wr_b edge acts on the 3rd posedge after wr_b rises, and the
  // Wishbone request is presented just before that edge.
  task automatic z80_push_wb_pop(input string tag, input logic [7:0] b);
    logic [31:0] rd, exp;
    logic        ack, push_ok;
    @(negedge clk);
    z_addr = PORT; z_data = b; z_wr_b = 1'b0;
    repeat (4) @(negedge clk);
    z_wr_b = 1'b1;
    repeat (2) @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = A_DATA;
    @(negedge clk);
    ack = wb_ack_out; rd = wb_data_out;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (6) @(negedge clk);
    push_ok = (z2h_q.size() < DEPTH);
    if (z2h_q.size() > 0) exp = {24'h0, z2h_q.pop_front()};
    else begin exp = 32'h0; exp_flags[0] = 1'b1; end
    if (push_ok) z2h_q.push_back(b);
    else exp_flags[2] = 1'b1;
    check({tag, " ack"}, 32'(ack), 32'd1);
    check(tag, rd, exp);
  endtask

  task automatic wait_irq(input string tag, input logic exp);
    logic seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (irq_out === exp) begin seen = 1'b1; break; end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  d, oeb;
    logic        dir, ack;

    reset_b = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0;
    z_addr = '0; z_data = '0; z_rd_b = 1'b1; z_wr_b = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst ack", 32'(wb_ack_out), 32'd0);
    check("rst wb_data", wb_data_out, 32'h0);
    check("rst irq", 32'(irq_out), 32'd0);
    check("rst io_out", 32'(io_out), 32'h0);
    check("rst io_oeb", 32'(io_oeb), 32'h0FFB_FFFF);
    reset_b = 1'b1;
    wb_read("rst status", A_STATUS, rd);
    check("rst status", rd, exp_status());

    // 1: fill H2Z, overflow, drain from Z80 side, underflow, clear flags
    for (int i = 0; i < 8; i++) host_push(8'h11 + 8'(i));
    host_push(8'h99);
    wb_read("h2z full status", A_STATUS, rd);
    check("h2z full status", rd, 32'h8008_0000);
    for (int i = 0; i < 8; i++) z80_pop("z80 h2z pop");
    z80_pop("z80 h2z empty pop");
    wb_read("h2z udf status", A_STATUS, rd);
    check("h2z udf status", rd, 32'hA000_0000);
    wb_write("clr flags", A_STATUS, 32'hF000_0000);
    exp_flags = 4'h0;
    wb_read("clr status", A_STATUS, rd);
    check("clr status", rd, exp_status());

    // 2: Z2H not-empty interrupt
    z80_write(PORT, 8'hA5);
    wb_write("irq_en=1", A_IRQEN, 32'h1);
    wait_irq("irq z2h rise", 1'b1);
    host_pop("z2h pop A5");
    check("irq held at ack", 32'(irq_out), 32'd1);
    @(negedge clk);
    check("irq fall", 32'(irq_out), 32'd0);
    wb_write("irq_en=0", A_IRQEN, 32'h0);

    // 3: Z80 status port, pad enables
    host_push(8'h42);
    for (int i = 1; i <= 8; i++) z80_write(PORT, 8'(i));
    z80_write(PORT + 8'd1, 8'hEE);
    z80_read(PORT + 8'd1, d, oeb, dir);
    check("z80 status", 32'(d), 32'h03);
    check("status oeb low", 32'(oeb), 32'h00);
    check("status bus_dir", 32'(dir), 32'd1);
    check("oeb released", 32'(io_oeb[15:8]), 32'hFF);
    z80_read(8'h55, d, oeb, dir);
    check("foreign port bus_dir", 32'(dir), 32'd0);
    check("foreign port oeb", 32'(oeb), 32'hFF);

    // 5: full Z2H, simultaneous push and pop -> pop wins, push dropped
    z80_push_wb_pop("full push+pop", 8'h77);
    wb_read("full push+pop status", A_STATUS, rd);
    check("full push+pop status", rd, exp_status());
    while (z2h_q.size() > 0) host_pop("z2h drain");
    // empty Z2H, simultaneous push and pop -> push wins, pop returns 0
    z80_push_wb_pop("empty push+pop", 8'h66);
    wb_read("empty push+pop status", A_STATUS, rd);
    check("empty push+pop status", rd, exp_status());
    host_pop("z2h pop 66");

    // 4: unmapped address, flag clear
    wb_xact(1'b0, BASE + 32'h10, 32'h0, rd, ack);
    check("unmapped no ack", 32'(ack), 32'd0);
    wb_write("clr flags 2", A_STATUS, 32'hF000_0000);
    exp_flags = 4'h0;
    wb_read("clr status 2", A_STATUS, rd);
    check("clr status 2", rd, exp_status());

    // H2Z empty interrupt and IRQ_EN readback
    z80_pop("z80 pop 42");
    wb_write("irq_en=2", A_IRQEN, 32'h2);
    wait_irq("irq h2z empty", 1'b1);
    wb_write("irq_en=7", A_IRQEN, 32'h7);
    wb_read("irq_en rb", A_IRQEN, rd);
`ifdef ZUBE_FIFO_THRESH_EN
    check("irq_en rb", rd, 32'h7);
`else
    check("irq_en rb", rd, 32'h3);
`endif
    wb_write("irq_en=0 b", A_IRQEN, 32'h0);
    wait_irq("irq off", 1'b0);

    // 6: threshold interrupt
    wb_write("thresh=3", A_THRESH, 32'h3);
    wb_read("thresh rb", A_THRESH, rd);
`ifdef ZUBE_FIFO_THRESH_EN
    check("thresh rb", rd, 32'h3);
`else
    check("thresh rb", rd, 32'h0);
`endif
    wb_write("irq_en=4", A_IRQEN, 32'h4);
    z80_write(PORT, 8'hC1);
    check("thresh irq after 1", 32'(irq_out), 32'd0);
    z80_write(PORT, 8'hC2);
    check("thresh irq after 2", 32'(irq_out), 32'd0);
    z80_write(PORT, 8'hC3);
`ifdef ZUBE_FIFO_THRESH_EN
    check("thresh irq after 3", 32'(irq_out), 32'd1);
`else
    check("thresh irq after 3", 32'(irq_out), 32'd0);
`endif

    // Async reset mid-transfer: Z80 read holding the bus plus a pending WB read
    host_push(8'h5A);
    @(negedge clk);
    z_addr = PORT + 8'd1; z_rd_b = 1'b0;
    repeat (6) @(negedge clk);
    check("pre-reset bus_dir", 32'(io_out[18]), 32'd1);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = A_DATA;
    #2 reset_b = 1'b0;
    #1;
    check("mid rst ack", 32'(wb_ack_out), 32'd0);
    check("mid rst wb_data", wb_data_out, 32'h0);
    check("mid rst irq", 32'(irq_out), 32'd0);
    check("mid rst io_out", 32'(io_out), 32'h0);
    check("mid rst io_oeb", 32'(io_oeb), 32'h0FFB_FFFF);
    wb_cyc = 1'b0; wb_stb = 1'b0; z_rd_b = 1'b1;
    h2z_q.delete(); z2h_q.delete(); exp_flags = 4'h0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    wb_read("post rst status", A_STATUS, rd);
    check("post rst status", rd, exp_status());
    check("post rst irq", 32'(irq_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
